// File: rtl/if_fetch_queue.sv
// rtl/if_fetch_queue.sv - PC generator and DEPTH-entry fetch queue feeding decode
module if_fetch_queue #(
    parameter int          FETCH_W  = 2,
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         exc_valid,
    input  logic [31:0]                  exc_pc,
    input  logic                         br_valid,
    input  logic [31:0]                  br_target,
    input  logic                         br_keep_slot,
    output logic                         imem_req,
    output logic [31:0]                  imem_addr,
    input  logic                         imem_ready,
    input  logic                         imem_rvalid,
    input  logic [32*FETCH_W-1:0]        imem_rdata,
    output logic [FETCH_W-1:0]           id_valid,
    output logic [32*FETCH_W-1:0]        id_inst,
    output logic [32*FETCH_W-1:0]        id_pc,
    output logic [FETCH_W-1:0]           id_adel,
    input  logic [$clog2(FETCH_W+1)-1:0] id_take
);

    localparam int          PTR_W     = $clog2(DEPTH);
    localparam int          CNT_W     = PTR_W + 1;
    localparam logic [31:0] GRP_BYTES = 32'(FETCH_W * 4);
    localparam logic [31:0] GRP_MASK  = ~(GRP_BYTES - 32'd1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             outstanding_q, outstanding_d;
    logic             drop_q, drop_d;
    logic             stall_q, stall_d;

    logic [31:0]      mem_inst_q [DEPTH];
    logic [31:0]      mem_inst_d [DEPTH];
    logic [31:0]      mem_pc_q   [DEPTH];
    logic [31:0]      mem_pc_d   [DEPTH];
    logic             mem_adel_q [DEPTH];
    logic             mem_adel_d [DEPTH];

    logic             redirect;
    logic             misaligned;
    logic [31:0]      aligned_pc;
    logic [31:0]      start_lane;
    logic [CNT_W-1:0] free;
    logic [CNT_W-1:0] pushed;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Fetch request generation, redirect/flush handling, response push and dequeue
    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        stall_d       = stall_q;
        mem_inst_d    = mem_inst_q;
        mem_pc_d      = mem_pc_q;
        mem_adel_d    = mem_adel_q;
        pushed        = '0;
        wptr          = tail_q;

        redirect   = exc_valid | br_valid;
        aligned_pc = fetch_pc_q & GRP_MASK;
        start_lane = (fetch_pc_q >> 2) & 32'(FETCH_W - 1);
        misaligned = (fetch_pc_q[1:0] != 2'b00);
        free       = CNT_W'(DEPTH) - count_q;

        imem_req  = !reset && !outstanding_q && !misaligned && !redirect &&
                    (free >= CNT_W'(FETCH_W));
        imem_addr = aligned_pc;

        if (redirect) begin
            fetch_pc_d = exc_valid ? exc_pc : br_target;
            stall_d    = 1'b0;
            // A response landing in the redirect cycle is consumed and thrown away;
            // otherwise the still-pending response must be dropped when it arrives.
            if (outstanding_q) begin
                if (imem_rvalid) begin
                    outstanding_d = 1'b0;
                    drop_d        = 1'b0;
                end else begin
                    drop_d = 1'b1;
                end
            end
            // Branch may retain the head entry as the delay slot.
            if (exc_valid || !br_keep_slot || count_q == '0) begin
                tail_d  = head_q;
                count_d = '0;
            end else begin
                tail_d  = head_q + PTR_W'(1);
                count_d = CNT_W'(1);
            end
        end else begin
            if (imem_req && imem_ready) begin
                outstanding_d = 1'b1;
            end
            if (imem_rvalid && outstanding_q) begin
                outstanding_d = 1'b0;
                drop_d        = 1'b0;
                if (!drop_q) begin
                    // Lanes below the entry offset belong to words before fetch_pc.
                    for (int i = 0; i < FETCH_W; i++) begin
                        if (32'(i) >= start_lane) begin
                            wptr             = tail_q + pushed[PTR_W-1:0];
                            mem_inst_d[wptr] = imem_rdata[32*i +: 32];
                            mem_pc_d[wptr]   = aligned_pc + 32'(4 * i);
                            mem_adel_d[wptr] = 1'b0;
                            pushed           = pushed + CNT_W'(1);
                        end
                    end
                    fetch_pc_d = aligned_pc + GRP_BYTES;
                end
            end else if (misaligned && !stall_q && free != '0) begin
                // Misaligned PC becomes a single tagged entry; fetch then waits for a redirect.
                mem_inst_d[tail_q] = 32'd0;
                mem_pc_d[tail_q]   = fetch_pc_q;
                mem_adel_d[tail_q] = 1'b1;
                pushed             = CNT_W'(1);
                stall_d            = 1'b1;
            end
            tail_d  = tail_q + pushed[PTR_W-1:0];
            head_d  = head_q + PTR_W'(id_take);
            count_d = count_q + pushed - CNT_W'(id_take);
        end
    end

    // Decode lanes present the oldest entries; empty lanes drive zero
    always_comb begin
        id_valid = '0;
        id_inst  = '0;
        id_pc    = '0;
        id_adel  = '0;
        rptr     = head_q;
        for (int i = 0; i < FETCH_W; i++) begin
            rptr = head_q + PTR_W'(i);
            if (count_q > CNT_W'(i)) begin
                id_valid[i]         = 1'b1;
                id_inst[32*i +: 32] = mem_inst_q[rptr];
                id_pc[32*i +: 32]   = mem_pc_q[rptr];
                id_adel[i]          = mem_adel_q[rptr];
            end
        end
    end

    // State and queue storage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            stall_q       <= 1'b0;
            for (int k = 0; k < DEPTH; k++) begin
                mem_inst_q[k] <= '0;
                mem_pc_q[k]   <= '0;
                mem_adel_q[k] <= 1'b0;
            end
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            stall_q       <= stall_d;
            mem_inst_q    <= mem_inst_d;
            mem_pc_q      <= mem_pc_d;
            mem_adel_q    <= mem_adel_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// tb/tb_if_fetch_queue.sv - randomized bench for if_fetch_queue against a queue-based reference model
module tb_if_fetch_queue;

    localparam int          FW     = 2;
    localparam int          DEPTH  = 8;
    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        adel;
    } ent_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              exc_valid;
    logic [31:0]       exc_pc;
    logic              br_valid;
    logic [31:0]       br_target;
    logic              br_keep_slot;
    logic              imem_req;
    logic [31:0]       imem_addr;
    logic              imem_ready;
    logic              imem_rvalid;
    logic [32*FW-1:0]  imem_rdata;
    logic [FW-1:0]     id_valid;
    logic [32*FW-1:0]  id_inst;
    logic [32*FW-1:0]  id_pc;
    logic [FW-1:0]     id_adel;
    logic [1:0]        id_take;

    if_fetch_queue #(.FETCH_W(FW), .DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
        .clk(clk), .reset(reset),
        .exc_valid(exc_valid), .exc_pc(exc_pc),
        .br_valid(br_valid), .br_target(br_target), .br_keep_slot(br_keep_slot),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc), .id_adel(id_adel),
        .id_take(id_take)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference model state
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_out, m_drop, m_stall;
    // instruction memory model state
    bit          pend;
    logic [31:0] pend_addr;
    int          lat_left;
    logic [31:0] seq_pc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h5a3c_00a5;
    endfunction

    function automatic logic [31:0] rand_target();
        int          k;
        logic [31:0] b;
        k = $urandom_range(0, 9);
        b = $urandom() & 32'hffff_fff8;
        if (k == 0)      return b | 32'($urandom_range(1, 3));
        else if (k == 1) return 32'hffff_fff8;
        else if (k <= 4) return b | 32'd4;
        else             return b;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc    = RST_PC;
        m_out   = 0;
        m_drop  = 0;
        m_stall = 0;
        pend    = 0;
    endtask

    // Hold reset across one edge, with a response on the bus if one is pending.
    task automatic reset_cycle();
        @(negedge clk);
        reset      = 1'b1;
        exc_valid  = 1'b0;
        br_valid   = 1'b0;
        imem_ready = 1'b1;
        id_take    = '0;
        imem_rvalid = pend;
        for (int i = 0; i < FW; i++) imem_rdata[32*i +: 32] = word_of(pend_addr + 32'(4 * i));
        #1;
        check("rst_req",   imem_req,  1'b0);
        check("rst_addr",  imem_addr, RST_PC);
        check("rst_valid", id_valid,  '0);
        check("rst_inst",  id_inst,   '0);
        check("rst_pc",    id_pc,     '0);
        check("rst_adel",  id_adel,   '0);
        model_reset();
    endtask

    task automatic step(input bit steady);
        int               r, avail, n_take, size0, first;
        bit               e_req;
        logic [31:0]      e_addr;
        logic [FW-1:0]    e_valid, e_adel;
        logic [32*FW-1:0] e_inst, e_pc;

        @(negedge clk);
        reset = 1'b0;
        if (steady) begin
            exc_valid  = 1'b0;
            br_valid   = 1'b0;
            imem_ready = 1'b1;
        end else begin
            r          = $urandom_range(0, 99);
            exc_valid  = (r < 3);
            br_valid   = (r >= 3 && r < 8);
            imem_ready = ($urandom_range(0, 3) != 0);
        end
        exc_pc       = rand_target();
        br_target    = rand_target();
        br_keep_slot = $urandom_range(0, 1);
        imem_rvalid  = pend && (lat_left == 0);
        for (int i = 0; i < FW; i++)
            imem_rdata[32*i +: 32] = imem_rvalid ? word_of(pend_addr + 32'(4 * i)) : $urandom();
        avail   = (q.size() < FW) ? q.size() : FW;
        n_take  = steady ? avail : $urandom_range(0, avail);
        id_take = 2'(n_take);

        e_req  = !m_out && (m_pc[1:0] == 2'b00) && !(exc_valid || br_valid) &&
                 (DEPTH - q.size() >= FW);
        e_addr = m_pc & ~32'(FW * 4 - 1);
        e_valid = '0; e_adel = '0; e_inst = '0; e_pc = '0;
        for (int i = 0; i < FW; i++) begin
            if (i < q.size()) begin
                e_valid[i]         = 1'b1;
                e_inst[32*i +: 32] = q[i].inst;
                e_pc[32*i +: 32]   = q[i].pc;
                e_adel[i]          = q[i].adel;
            end
        end

        #1;
        check("imem_req",  imem_req,  e_req);
        check("imem_addr", imem_addr, e_addr);
        check("id_valid",  id_valid,  e_valid);
        check("id_inst",   id_inst,   e_inst);
        check("id_pc",     id_pc,     e_pc);
        check("id_adel",   id_adel,   e_adel);
        if (steady) begin
            for (int i = 0; i < n_take; i++) begin
                check("seq_pc", id_pc[32*i +: 32], seq_pc);
                seq_pc = seq_pc + 32'd4;
            end
        end

        // advance the reference model across the coming clock edge
        size0 = q.size();
        if (exc_valid || br_valid) begin
            if (exc_valid || !br_keep_slot || q.size() == 0) q.delete();
            else while (q.size() > 1) void'(q.pop_back());
            m_pc    = exc_valid ? exc_pc : br_target;
            m_stall = 0;
            if (m_out) begin
                if (imem_rvalid) begin m_out = 0; m_drop = 0; end
                else m_drop = 1;
            end
        end else begin
            for (int i = 0; i < n_take; i++) void'(q.pop_front());
            if (imem_rvalid) begin
                m_out = 0;
                if (m_drop) m_drop = 0;
                else begin
                    first = int'((m_pc >> 2) % FW);
                    for (int i = first; i < FW; i++)
                        q.push_back('{inst: imem_rdata[32*i +: 32],
                                      pc: e_addr + 32'(4 * i), adel: 1'b0});
                    m_pc = e_addr + 32'(FW * 4);
                end
            end else if (m_pc[1:0] != 2'b00 && !m_stall && size0 < DEPTH) begin
                q.push_back('{inst: 32'd0, pc: m_pc, adel: 1'b1});
                m_stall = 1;
            end
            if (e_req && imem_ready) m_out = 1;
        end

        if (imem_rvalid) pend = 0;
        else if (pend && lat_left > 0) lat_left--;
        if (e_req && imem_ready) begin
            pend      = 1;
            pend_addr = e_addr;
            lat_left  = steady ? 0 : $urandom_range(0, 2);
        end
    endtask

    initial begin
        reset        = 1'b1;
        exc_valid    = 1'b0;
        exc_pc       = '0;
        br_valid     = 1'b0;
        br_target    = '0;
        br_keep_slot = 1'b0;
        imem_ready   = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = '0;
        id_take      = '0;
        pend_addr    = '0;
        lat_left     = 0;
        seq_pc       = RST_PC;
        model_reset();

        reset_cycle();
        for (int n = 0; n < 3000; n++) begin
            if (n > 0 && n % 600 == 0) begin
                // wait for a response to be due, then reset on top of it
                for (int w = 0; w < 50 && !(pend && lat_left == 0); w++) step(1'b0);
                reset_cycle();
            end else begin
                step(1'b0);
            end
        end

        reset_cycle();
        seq_pc = RST_PC;
        for (int n = 0; n < 300; n++) step(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
